iiitb_dmem_resp: RTL
====================

Name: iiitb_dmem_resp

Overview:
Data-memory responder for the iiitb_rv32i pipeline's MEM stage. The core acts as initiator: it issues LW/SW requests. This block answers them from a word-addressed data array, with a programmable read/write latency and response backpressure. It replaces the core's ideal zero-wait DM array, so the core can be exercised against a memory that stalls.

Parameters:
DEPTH, 32, number of 32-bit words in the data array.
AW, 5, index width used internally; must satisfy 2**AW >= DEPTH.
LATENCY, 1, cycles from request acceptance to rsp_valid assertion; legal range 1..4.

Ports:
clk  input  1  single clock, rising edge.
RN  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store (SW), 0 = load (LW).
req_addr  input  32  word address, used directly as the array index (not a byte address).
req_wdata  input  32  store data.
req_be  input  4  store byte enables; bit i covers byte [8i+7:8i]; ignored for loads.
rsp_valid  output  1  response present.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  32  load data; 0 for stores and for errors.
rsp_we  output  1  echo of req_we for the request being answered.
rsp_err  output  1  address was out of range (req_addr >= DEPTH).
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RN low, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0, busy=0, latency counter=0, all DEPTH words cleared to 0.
- Reset mid-operation aborts any in-flight request; no response is produced for it.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready.
- req_ready = (state==IDLE). Exactly one request is outstanding at a time.
- Actions on the acceptance edge:
  - A store commits its enabled bytes to the array.
  - A load captures the addressed word into the response register.
  - rsp_we is latched.
  - rsp_err is latched as (req_addr >= DEPTH), compared at the full 32-bit width.
- Error requests: the array is not modified and rsp_rdata=0. The response is still returned.
- Store with req_be=4'b0000: array unchanged, normal response with rsp_err=0.
- States:
  - IDLE: on acceptance, go to RESP if LATENCY==1; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: decrement cnt each cycle; when cnt==0, go to RESP on the next edge.
  - RESP: rsp_valid=1. Response fields stay stable until rsp_valid && rsp_ready on an edge, then go to IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- Back-to-back throughput: minimum LATENCY+1 cycles per request. The IDLE cycle after a handshake is mandatory.
- Outside RESP, rsp_valid=0; rsp_rdata, rsp_we and rsp_err hold their last values.
- rsp_ready may be asserted early. It has no effect until the RESP state is reached.
- Request inputs are ignored while req_ready=0. The initiator must hold them stable until it sees acceptance.
- Read data is the array content at the acceptance edge. A store to the same word later does not alter a pending load response (impossible anyway, since only one request is outstanding).

Decomposition:
- Shared package iiitb_pkg holds:
  - state encoding (IDLE/WAIT/RESP) as a 2-bit typedef;
  - constants LW=3'd0 and SW=3'd1 and the M_TYPE opcode, reused by the core's MEM stage;
  - XLEN=32.
- One sub-module is natural: iiitb_dmem_array. It is the DEPTH x 32 storage with byte-enabled synchronous write, synchronous read into the response register, and async-low clear. The responder FSM and latency counter remain in the top module.

Test Plan:
- Reset check: RN pulsed low mid-cycle -> outputs go to reset values immediately with no clk edge; req_ready=1; a load from addr 3 returns 0.
- Store then load: SW addr 5, wdata 32'hDEADBEEF, be 4'hF, then LW addr 5 with LATENCY=1 -> each rsp_valid rises 1 cycle after acceptance; load rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Byte enables: SW addr 2 data 32'h11223344 be 4'hF, then SW addr 2 data 32'hAABBCCDD be 4'b0101 -> LW addr 2 returns 32'h11BB33DD.
- Out of range: SW addr 40 data 32'hFFFFFFFF, then LW addr 40 -> both responses rsp_err=1, load rsp_rdata=0; a full scan of addrs 0..31 shows no corruption.
- Latency and backpressure: LATENCY=3, LW addr 5 with rsp_ready held low 4 cycles -> rsp_valid rises 3 cycles after acceptance and holds stable data 32'hDEADBEEF with req_ready=0 throughout; after the handshake, req_ready returns 1 one cycle later.
- Reset mid-WAIT: LATENCY=4, accept LW, drop RN 2 cycles later -> rsp_valid never asserts; state=IDLE, array cleared.

Source files
------------

// File: rtl/iiitb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_pkg
// Purpose  : Shared definitions for the iiitb_rv32i memory path: responder
//            state encoding, MEM-stage access codes and the data width.
// Revision : 1.0 - initial release
// ============================================================================
package iiitb_pkg;

  // Data path width of the core
  localparam int XLEN = 32;

  // MEM-stage access codes, shared with the core's MEM stage
  localparam logic [2:0] LW = 3'd0;
  localparam logic [2:0] SW = 3'd1;

  // Opcode of the memory-access instruction class
  localparam logic [6:0] M_TYPE = 7'b0000011;

  // Responder state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/iiitb_dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_dmem_array
// Purpose  : DEPTH x XLEN data storage with byte-enabled synchronous write,
//            synchronous read into the response data register and
//            asynchronous active-low clear of every word.
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_dmem_array
  import iiitb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,    // commit enabled bytes of wdata to addr
  input  logic              rd_en,    // capture word at addr into rdata
  input  logic              zero_en,  // load zero into rdata (stores, errors)
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rdata_d;

  // Byte-lane merge of store data into the addressed word
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (be[b]) begin
          mem_d[addr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Response data: zero for stores/errors, array word for loads, else hold
  always_comb begin
    rdata_d = rdata_q;
    if (zero_en) begin
      rdata_d = '0;
    end else if (rd_en) begin
      rdata_d = mem_q[addr];
    end
  end

  // Storage and response data registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/iiitb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_dmem_resp
// Purpose  : Data-memory responder for the MEM stage. Accepts one LW/SW at a
//            time, answers after LATENCY cycles and holds the response until
//            the initiator takes it.
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_dmem_resp
  import iiitb_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic              busy
);

  // WAIT spans LATENCY-1 cycles: counter loads LATENCY-2 and exits on zero
  localparam logic [1:0]      CNT_INIT = 2'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic [XLEN-1:0] DEPTH_W  = XLEN'(DEPTH);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rsp_we_q, rsp_we_d;
  logic       rsp_err_q, rsp_err_d;

  logic       accept;
  logic       addr_err;
  logic       wr_en;
  logic       rd_en;
  logic       zero_en;

  // Request decode; range check uses the full address width
  always_comb begin
    accept   = req_valid && (state_q == ST_IDLE);
    addr_err = (req_addr >= DEPTH_W);
    wr_en    = accept && req_we && !addr_err;
    rd_en    = accept && !req_we && !addr_err;
    zero_en  = accept && (req_we || addr_err);
  end

  // State, latency counter and latched response attributes
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      rsp_we_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_we_q  <= rsp_we_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Next-state: accept -> (WAIT ->) RESP -> handshake -> IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_we_d  = rsp_we_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_we_d  = req_we;
          rsp_err_d = addr_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    rsp_we    = rsp_we_q;
    rsp_err   = rsp_err_q;
  end

  iiitb_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (RN),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .zero_en (zero_en),
    .addr    (req_addr[AW-1:0]),
    .wdata   (req_wdata),
    .be      (req_be),
    .rdata   (rsp_rdata)
  );

endmodule
`default_nettype wire
